// File: rtl/slide_scan.sv
// slide_scan: round-robin A2D scanner. Each slot requests a conversion on its
// mapped channel, waits (bounded) for completion, and folds the result into a
// per-slot exponential smoothing filter. A slot that times out is retried.
module slide_scan #(
  parameter int unsigned          NUM_CH    = 6,
  parameter int unsigned          RES_W     = 12,
  parameter logic [NUM_CH*3-1:0]  CH_MAP    = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int unsigned          AVG_SHIFT = 2,
  parameter int unsigned          TIMEOUT   = 4095
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    strt_cnv,
  output logic [2:0]              chnnl,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  output logic [NUM_CH*RES_W-1:0] pot,
  output logic [NUM_CH-1:0]       upd,
  output logic                    sweep_done,
  output logic                    err
);

  localparam int unsigned SlotW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Counter value during the last WAIT cycle that is still allowed.
  localparam logic [CntW-1:0]  CntLast  = CntW'(TIMEOUT - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } state_e;

  state_e                    r_state, w_state_nxt;
  logic [SlotW-1:0]          r_slot, w_slot_nxt;
  logic [2:0]                r_chnnl, w_chnnl_nxt;
  logic [CntW-1:0]           r_cnt, w_cnt_nxt;
  logic [NUM_CH*RES_W-1:0]   r_pot, w_pot_nxt;
  logic [NUM_CH-1:0]         r_seeded, w_seeded_nxt;
  logic [NUM_CH-1:0]         r_upd, w_upd_nxt;
  logic                      r_sweep, w_sweep_nxt;
  logic                      r_err, w_err_nxt;

  logic                      w_done;
  logic                      w_tmo;
  logic                      w_wrap;
  logic [RES_W-1:0]          w_cur_pot;
  logic                      w_cur_seeded;
  logic signed [RES_W:0]     w_diff;
  logic signed [RES_W:0]     w_step;
  logic [RES_W-1:0]          w_filt;

  // Completion always beats a coincident timeout.
  assign w_done = (r_state == StWait) && cnv_cmplt;
  assign w_tmo  = (r_state == StWait) && !cnv_cmplt && (r_cnt == CntLast);
  assign w_wrap = (r_slot == SlotLast);

  // Select the stored value and seeded flag of the active slot.
  always_comb begin
    w_cur_pot    = '0;
    w_cur_seeded = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_slot == SlotW'(k)) begin
        w_cur_pot    = r_pot[k*RES_W +: RES_W];
        w_cur_seeded = r_seeded[k];
      end
    end
  end

  // Smoothing filter: pot += (res - pot) >>> AVG_SHIFT; first sample seeds.
  always_comb begin
    w_diff = $signed({1'b0, res}) - $signed({1'b0, w_cur_pot});
    w_step = w_diff >>> AVG_SHIFT;
    if ((AVG_SHIFT == 0) || !w_cur_seeded) begin
      w_filt = res;
    end else begin
      // The step never overshoots res, so dropping the top bit is exact.
      w_filt = RES_W'($unsigned(w_step) + {1'b0, w_cur_pot});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (en) w_state_nxt = StStart;
      end
      StStart: begin
        w_state_nxt = StWait;
      end
      StWait: begin
        // en only matters once the conversion has finished or been abandoned.
        if (w_done || w_tmo) w_state_nxt = en ? StStart : StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Outputs and datapath next-state values.
  always_comb begin
    strt_cnv     = (r_state == StStart);
    w_slot_nxt   = r_slot;
    w_chnnl_nxt  = r_chnnl;
    w_cnt_nxt    = r_cnt;
    w_pot_nxt    = r_pot;
    w_seeded_nxt = r_seeded;
    w_upd_nxt    = '0;
    w_sweep_nxt  = 1'b0;
    w_err_nxt    = w_tmo;

    if (r_state == StStart) begin
      w_cnt_nxt = '0;
    end else if (r_state == StWait) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end

    if (w_done) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_slot == SlotW'(k)) begin
          w_pot_nxt[k*RES_W +: RES_W] = w_filt;
          w_seeded_nxt[k]             = 1'b1;
          w_upd_nxt[k]                = 1'b1;
        end
      end
      w_sweep_nxt = w_wrap;
      w_slot_nxt  = w_wrap ? '0 : r_slot + SlotW'(1);
    end

    // Channel is latched on entry to START so it tracks the advanced slot.
    if (w_state_nxt == StStart) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_slot_nxt == SlotW'(k)) w_chnnl_nxt = CH_MAP[k*3 +: 3];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '0;
      r_chnnl  <= CH_MAP[2:0];
      r_cnt    <= '0;
      r_pot    <= '0;
      r_seeded <= '0;
      r_upd    <= '0;
      r_sweep  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_slot   <= w_slot_nxt;
      r_chnnl  <= w_chnnl_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pot    <= w_pot_nxt;
      r_seeded <= w_seeded_nxt;
      r_upd    <= w_upd_nxt;
      r_sweep  <= w_sweep_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign chnnl      = r_chnnl;
  assign pot        = r_pot;
  assign upd        = r_upd;
  assign sweep_done = r_sweep;
  assign err        = r_err;

endmodule
